// File: rtl/ofdm_dsc_extract.sv
// Data-subcarrier extractor: buffers 64-bin OFDM symbols in a ping-pong RAM
// and streams out the 48 data bins in logical order -26..+26.
module ofdm_dsc_extract #(
  parameter int DW  = 16,
  parameter int NSC = 64
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [2*DW-1:0] DAT_I,
  input  logic            CYC_I,
  input  logic            WE_I,
  input  logic            STB_I,
  output logic            ACK_O,
  output logic [2*DW-1:0] DAT_O,
  output logic            WE_O,
  output logic            STB_O,
  output logic            CYC_O,
  input  logic            ACK_I
);

  localparam int AW = $clog2(NSC);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wrIdx_q, wrIdx_d;
  logic              wrBank_q, wrBank_d;
  logic [1:0]        full_q, full_d;
  logic              rdBank_q, rdBank_d;
  logic [5:0]        rdCnt_q, rdCnt_d;
  logic [2*DW-1:0]   dat_q;
  logic              cycO_q, cycO_d;
  logic              stbOut;

  logic [2*DW-1:0]   mem [0:2*NSC-1];

  logic              wrEn, wrDone, rdLast, rdAdv, rdEn;
  logic [AW:0]       rdAddr;

  // Logical data-subcarrier index -> FFT bin: six contiguous runs.
  function automatic logic [5:0] binOf(input logic [5:0] i);
    logic [5:0] b;
    if (i < 6'd5)       b = i + 6'd38;
    else if (i < 6'd18) b = i + 6'd39;
    else if (i < 6'd24) b = i + 6'd40;
    else if (i < 6'd30) b = i - 6'd23;
    else if (i < 6'd43) b = i - 6'd22;
    else                b = i - 6'd21;
    return b;
  endfunction

  assign ACK_O  = CYC_I & STB_I & ~full_q[wrBank_q];
  assign wrEn   = ACK_O & WE_I;
  assign wrDone = wrEn && (wrIdx_q == AW'(NSC - 1));
  assign rdLast = (state_q == S_OUT) && ACK_I && (rdCnt_q == 6'd47);
  assign rdAdv  = (state_q == S_OUT) && ACK_I && !rdLast;
  assign rdEn   = (state_q == S_LOAD) || rdAdv;
  assign rdAddr = {rdBank_q, binOf(rdCnt_d)};

  always_comb begin
    wrIdx_d  = wrIdx_q;
    wrBank_d = wrBank_q;
    full_d   = full_q;
    rdBank_d = rdBank_q;
    rdCnt_d  = rdCnt_q;
    if (!CYC_I) begin
      wrIdx_d = '0;
    end else if (wrEn) begin
      wrIdx_d = wrDone ? '0 : wrIdx_q + 1'b1;
    end
    if (wrDone) begin
      full_d[wrBank_q] = 1'b1;
      wrBank_d         = ~wrBank_q;
    end
    // The read side only ever releases the bank the write side is not filling.
    if (rdLast) begin
      full_d[rdBank_q] = 1'b0;
      rdBank_d         = ~rdBank_q;
      rdCnt_d          = '0;
    end else if (rdAdv) begin
      rdCnt_d = rdCnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (full_q[rdBank_q]) state_d = S_LOAD;
      S_LOAD: state_d = S_OUT;
      S_OUT:  if (rdLast) state_d = full_d[~rdBank_q] ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stbOut = (state_q == S_OUT);
    cycO_d = cycO_q;
    if (state_d == S_OUT) begin
      cycO_d = 1'b1;
    end else if ((state_d == S_IDLE) && !CYC_I && (full_d == 2'b00)) begin
      cycO_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q  <= S_IDLE;
      wrIdx_q  <= '0;
      wrBank_q <= 1'b0;
      full_q   <= 2'b00;
      rdBank_q <= 1'b0;
      rdCnt_q  <= '0;
      dat_q    <= '0;
      cycO_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wrIdx_q  <= wrIdx_d;
      wrBank_q <= wrBank_d;
      full_q   <= full_d;
      rdBank_q <= rdBank_d;
      rdCnt_q  <= rdCnt_d;
      cycO_q   <= cycO_d;
      if (rdEn) dat_q <= mem[rdAddr];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (wrEn) mem[{wrBank_q, wrIdx_q}] <= DAT_I;
  end

  assign DAT_O = dat_q;
  assign STB_O = stbOut;
  assign WE_O  = stbOut;
  assign CYC_O = cycO_q;

endmodule

// File: tb/tb_ofdm_dsc_extract.sv
// Scoreboard bench for ofdm_dsc_extract: directed symbols, expected words
// queued on issue and compared by an independent output monitor.
module tb_ofdm_dsc_extract;

  localparam int DW = 16;

  logic            CLK_I = 1'b0;
  logic            RST_I;
  logic [2*DW-1:0] DAT_I;
  logic            CYC_I, WE_I, STB_I, ACK_O;
  logic [2*DW-1:0] DAT_O;
  logic            WE_O, STB_O, CYC_O, ACK_I;

  int checks = 0;
  int errors = 0;
  int cycCnt = 0;
  logic [31:0] sbQ[$];
  int binTab[48];

  int  outCount, cycoFalls, stalls, firstStallAcc, accepted;
  int  stbRiseCyc, lastAccCyc;
  bit  ackRand = 1'b0;
  bit  ackLevel = 1'b1;
  bit  abortRun = 1'b0;

  ofdm_dsc_extract #(.DW(DW), .NSC(64)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I),
    .WE_I(WE_I), .STB_I(STB_I), .ACK_O(ACK_O), .DAT_O(DAT_O),
    .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cycCnt <= cycCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wordOf(input int symId, input int bin);
    return {16'(symId * 256 + bin), 16'(bin)};
  endfunction

  task automatic clearStats();
    outCount = 0; cycoFalls = 0; stalls = 0; firstStallAcc = -1;
    accepted = 0; stbRiseCyc = -1; lastAccCyc = -1;
  endtask

  // Sends nWords of one symbol; queues the 48 expected outputs if push is set.
  task automatic applyStimulus(input int symId, input int nWords, input bit randGap, input bit push);
    for (int k = 0; k < nWords && !abortRun; k++) begin
      if (randGap) begin
        while ($urandom_range(0, 2) == 0) begin
          STB_I = 1'b0; WE_I = 1'b0;
          @(posedge CLK_I); #1;
        end
      end
      STB_I = 1'b1; WE_I = 1'b1;
      DAT_I = wordOf(symId, k);
      for (int w = 0; ; w++) begin
        @(negedge CLK_I);
        if (ACK_O) break;
        stalls++;
        if (firstStallAcc < 0) firstStallAcc = accepted;
        if (w > 1000) begin
          checks++; errors++;
          $display("[TB] FAIL input_timeout: sym %0d word %0d never accepted", symId, k);
          abortRun = 1'b1;
          break;
        end
        @(posedge CLK_I); #1;
      end
      lastAccCyc = cycCnt + 1;
      @(posedge CLK_I); #1;
      accepted++;
    end
    STB_I = 1'b0; WE_I = 1'b0;
    if (push && !abortRun)
      for (int i = 0; i < 48; i++) sbQ.push_back(wordOf(symId, binTab[i]));
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sbQ.size() != 0 || STB_O) && n < budget) begin
      @(posedge CLK_I); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d words still pending, need 0", sbQ.size());
      sbQ.delete();
    end
    repeat (3) @(posedge CLK_I);
    #1;
  endtask

  initial begin
    ACK_I = 1'b1;
    forever begin
      @(posedge CLK_I); #1;
      ACK_I = ackRand ? 1'($urandom_range(0, 1)) : ackLevel;
    end
  end

  // Output monitor: scoreboard pops, hold-stability and WE_O tracking.
  initial begin
    bit heldPrev = 1'b0, stbPrev = 1'b0, cycPrev = 1'b0;
    logic [31:0] heldDat = '0;
    logic [31:0] exp;
    forever begin
      @(negedge CLK_I);
      if (!RST_I) begin
        heldPrev = 1'b0; stbPrev = 1'b0; cycPrev = 1'b0;
      end else begin
        checkOutput("we_eq_stb", 32'(WE_O), 32'(STB_O));
        if (heldPrev) begin
          checkOutput("hold_stb", 32'(STB_O), 32'd1);
          checkOutput("hold_dat", DAT_O, heldDat);
        end
        if (STB_O && !stbPrev && stbRiseCyc < 0) stbRiseCyc = cycCnt;
        if (STB_O && ACK_I) begin
          outCount++;
          if (sbQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_output: got %0h expected none", DAT_O);
          end else begin
            exp = sbQ.pop_front();
            checkOutput("dat_o", DAT_O, exp);
          end
        end
        if (cycPrev && !CYC_O) cycoFalls++;
        heldPrev = STB_O && !ACK_I;
        heldDat  = DAT_O;
        stbPrev  = STB_O;
        cycPrev  = CYC_O;
      end
    end
  end

  initial begin
    #800000;
    checks++; errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int starts[6] = '{38, 44, 58, 1, 8, 22};
    int lens[6]   = '{5, 13, 6, 6, 13, 5};
    int idx = 0;
    for (int r = 0; r < 6; r++)
      for (int j = 0; j < lens[r]; j++) begin
        binTab[idx] = starts[r] + j;
        idx++;
      end

    RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
    clearStats();
    repeat (3) @(posedge CLK_I);
    #1;
    checkOutput("rst_stb", 32'(STB_O), 32'd0);
    checkOutput("rst_cyc", 32'(CYC_O), 32'd0);
    checkOutput("rst_we", 32'(WE_O), 32'd0);
    checkOutput("rst_ack", 32'(ACK_O), 32'd0);
    checkOutput("rst_dat", DAT_O, 32'd0);
    RST_I = 1'b1;
    @(posedge CLK_I); #1;

    $display("[TB] single symbol");
    clearStats();
    CYC_I = 1'b1;
    applyStimulus(0, 64, 1'b0, 1'b1);
    CYC_I = 1'b0;
    waitDrain(500);
    checkOutput("latency", 32'(stbRiseCyc - lastAccCyc), 32'd2);
    checkOutput("single_count", 32'(outCount), 32'd48);
    checkOutput("single_cyco_fall", 32'(cycoFalls), 32'd1);

    $display("[TB] back-to-back symbols");
    clearStats();
    CYC_I = 1'b1;
    for (int s = 1; s <= 10; s++) applyStimulus(s, 64, 1'b0, 1'b1);
    CYC_I = 1'b0;
    waitDrain(1000);
    checkOutput("b2b_count", 32'(outCount), 32'd480);
    checkOutput("b2b_stalls", 32'(stalls), 32'd0);
    checkOutput("b2b_cyco_fall", 32'(cycoFalls), 32'd1);

    $display("[TB] backpressure");
    clearStats();
    ackLevel = 1'b0;
    fork
      begin
        CYC_I = 1'b1;
        for (int s = 11; s <= 14; s++) applyStimulus(s, 64, 1'b0, 1'b1);
        CYC_I = 1'b0;
      end
      begin
        repeat (300) @(posedge CLK_I);
        ackLevel = 1'b1;
      end
    join
    waitDrain(1000);
    checkOutput("bp_first_stall", 32'(firstStallAcc), 32'd128);
    checkOutput("bp_count", 32'(outCount), 32'd192);
    checkOutput("bp_cyco_fall", 32'(cycoFalls), 32'd1);

    $display("[TB] random handshake");
    clearStats();
    ackRand = 1'b1;
    CYC_I = 1'b1;
    for (int s = 15; s <= 22; s++) applyStimulus(s, 64, 1'b1, 1'b1);
    CYC_I = 1'b0;
    waitDrain(4000);
    ackRand = 1'b0; ackLevel = 1'b1;
    checkOutput("rand_count", 32'(outCount), 32'd384);

    $display("[TB] partial symbol");
    clearStats();
    CYC_I = 1'b1;
    applyStimulus(23, 30, 1'b0, 1'b0);
    CYC_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    #1;
    CYC_I = 1'b1;
    applyStimulus(24, 64, 1'b0, 1'b1);
    CYC_I = 1'b0;
    waitDrain(500);
    checkOutput("partial_count", 32'(outCount), 32'd48);

    $display("[TB] reset mid-readout");
    clearStats();
    CYC_I = 1'b1;
    applyStimulus(25, 64, 1'b0, 1'b1);
    applyStimulus(26, 64, 1'b0, 1'b1);
    CYC_I = 1'b0;
    for (int n = 0; outCount < 68 && n < 500; n++) @(negedge CLK_I);
    checkOutput("rst_mid_reached", 32'(outCount >= 68), 32'd1);
    @(posedge CLK_I); #3;
    RST_I = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("arst_stb", 32'(STB_O), 32'd0);
    checkOutput("arst_we", 32'(WE_O), 32'd0);
    checkOutput("arst_cyc", 32'(CYC_O), 32'd0);
    checkOutput("arst_dat", DAT_O, 32'd0);
    checkOutput("arst_ack", 32'(ACK_O), 32'd0);
    @(posedge CLK_I); #3;
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    clearStats();
    CYC_I = 1'b1;
    applyStimulus(27, 64, 1'b0, 1'b1);
    CYC_I = 1'b0;
    waitDrain(500);
    checkOutput("post_rst_count", 32'(outCount), 32'd48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
